word_bus_mem16_bridge: RTL and testbench



---
 rtl/word_bus_mem16_bridge.sv | 168 ++++++++++++++++
 tb/tb_word_bus_mem16_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_bus_mem16_bridge.sv
`default_nettype none
// ============================================================================
// word_bus_mem16_bridge : 32/8-bit word command port to 16-bit req/ack memory
// Revision: 1.0
// ============================================================================
module word_bus_mem16_bridge #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        word_rd,
  input  logic        word_wr,
  input  logic        word_32bit,
  input  logic [25:0] word_addr,
  input  logic [31:0] word_data,
  output logic [31:0] word_q,
  output logic        word_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC1 = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_ACC2 = 2'd3;

  localparam int         GAP_M1   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [1:0] GAP_INIT = GAP_M1[1:0];

  logic [1:0]  state_q, state_d;
  logic        busy_q, busy_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        is32_q, is32_d;
  logic [24:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] lo_data_q, lo_data_d;
  logic [15:0] hi_q, hi_d;
  logic [31:0] rdq_q, rdq_d;
  logic [1:0]  gap_q, gap_d;
  logic        ack;
  logic [7:0]  rd_byte;

  assign ack     = req_q & mem_ack;
  // Byte lane follows the enable issued for the 8-bit request.
  assign rd_byte = be_q[0] ? mem_rdata[7:0] : mem_rdata[15:8];

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    req_d     = req_q;
    we_d      = we_q;
    is32_d    = is32_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    lo_data_d = lo_data_q;
    hi_d      = hi_q;
    rdq_d     = rdq_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        if (word_rd || word_wr) begin
          state_d   = S_ACC1;
          busy_d    = 1'b1;
          req_d     = 1'b1;
          we_d      = word_wr;
          is32_d    = word_32bit;
          lo_data_d = word_data[15:0];
          if (word_32bit) begin
            addr_d  = {word_addr[25:2], 1'b0};
            be_d    = 2'b11;
            wdata_d = word_data[31:16];
          end else begin
            addr_d  = word_addr[25:1];
            be_d    = word_addr[0] ? 2'b01 : 2'b10;
            wdata_d = {word_data[7:0], word_data[7:0]};
          end
        end
      end
      S_ACC1: begin
        if (ack) begin
          if (!is32_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            req_d   = 1'b0;
            if (!we_q) rdq_d = {4{rd_byte}};
          end else begin
            hi_d = mem_rdata;
            if (GAP_CYCLES == 0) begin
              state_d = S_ACC2;
              addr_d  = {addr_q[24:1], 1'b1};
              wdata_d = lo_data_q;
            end else begin
              state_d = S_GAP;
              req_d   = 1'b0;
              gap_d   = GAP_INIT;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == 2'd0) begin
          state_d = S_ACC2;
          req_d   = 1'b1;
          addr_d  = {addr_q[24:1], 1'b1};
          wdata_d = lo_data_q;
        end else begin
          gap_d = gap_q - 2'd1;
        end
      end
      default: begin
        if (ack) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          req_d   = 1'b0;
          if (!we_q) rdq_d = {hi_q, mem_rdata};
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      is32_q    <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      lo_data_q <= '0;
      hi_q      <= '0;
      rdq_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
      we_q      <= we_d;
      is32_q    <= is32_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      lo_data_q <= lo_data_d;
      hi_q      <= hi_d;
      rdq_q     <= rdq_d;
      gap_q     <= gap_d;
    end
  end

  assign word_q    = rdq_q;
  assign word_busy = busy_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_word_bus_mem16_bridge.sv
`default_nettype none
// Randomized bench: byte-addressed reference memory plus a 16-bit req/ack responder.
module tb_word_bus_mem16_bridge;

  typedef struct {
    logic [24:0] addr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wdata;
  } req_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        word_rd = 1'b0, word_wr = 1'b0, word_32bit = 1'b0;
  logic [25:0] word_addr = '0;
  logic [31:0] word_data = '0;
  logic [31:0] word_q;
  logic        word_busy, mem_req, mem_we;
  logic [24:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  logic        g0_rd = 1'b0, g0_wr = 1'b0, g0_32 = 1'b0, g0_ack = 1'b0;
  logic [25:0] g0_addr = '0;
  logic [31:0] g0_data = '0;
  logic [15:0] g0_rdata = '0;
  logic [31:0] g0_q;
  logic        g0_busy, g0_req, g0_we;
  logic [24:0] g0_maddr;
  logic [1:0]  g0_be;
  logic [15:0] g0_wdata;

  int n_checks = 0;
  int n_fail = 0;
  int force_lat = -1;
  req_t reqs[$];
  int   lats[$];
  logic [15:0] mem16[logic [24:0]];
  logic [7:0]  rb[logic [25:0]];
  logic [31:0] exp_q = '0;

  always #5 clk_sys = ~clk_sys;

  word_bus_mem16_bridge #(.GAP_CYCLES(1)) dut (
    .clk_sys(clk_sys), .reset(reset), .word_rd(word_rd), .word_wr(word_wr),
    .word_32bit(word_32bit), .word_addr(word_addr), .word_data(word_data),
    .word_q(word_q), .word_busy(word_busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  word_bus_mem16_bridge #(.GAP_CYCLES(0)) dut_g0 (
    .clk_sys(clk_sys), .reset(reset), .word_rd(g0_rd), .word_wr(g0_wr),
    .word_32bit(g0_32), .word_addr(g0_addr), .word_data(g0_data),
    .word_q(g0_q), .word_busy(g0_busy), .mem_req(g0_req), .mem_we(g0_we),
    .mem_addr(g0_maddr), .mem_be(g0_be), .mem_wdata(g0_wdata),
    .mem_rdata(g0_rdata), .mem_ack(g0_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [25:0] b);
    return b[7:0] ^ b[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] gb(input logic [25:0] b);
    return rb.exists(b) ? rb[b] : init_byte(b);
  endfunction

  function automatic logic [15:0] rd_word(input logic [24:0] w);
    return mem16.exists(w) ? mem16[w] : {init_byte({w, 1'b0}), init_byte({w, 1'b1})};
  endfunction

  // Memory responder: random (or forced) ack latency, spurious acks while idle.
  initial begin : responder
    bit   active;
    int   cnt;
    req_t cur;
    logic [15:0] w;
    active = 0; cnt = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    cur = '{addr: '0, we: 1'b0, be: 2'b00, wdata: '0};
    forever begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      if (!mem_req) begin
        active = 0;
        if ($urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = 16'($urandom);
        end
      end else begin
        if (!active) begin
          active = 1;
          cur = '{addr: mem_addr, we: mem_we, be: mem_be, wdata: mem_wdata};
          reqs.push_back(cur);
          cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
          lats.push_back(cnt);
        end else begin
          chk("stable_addr", 32'(mem_addr), 32'(cur.addr));
          chk("stable_we", 32'(mem_we), 32'(cur.we));
          chk("stable_be", 32'(mem_be), 32'(cur.be));
          chk("stable_wdata", 32'(mem_wdata), 32'(cur.wdata));
        end
        if (cnt == 0) begin
          mem_ack = 1'b1;
          w = rd_word(mem_addr);
          if (mem_we) begin
            if (mem_be[1]) w[15:8] = mem_wdata[15:8];
            if (mem_be[0]) w[7:0] = mem_wdata[7:0];
            mem16[mem_addr] = w;
            mem_rdata = 16'($urandom);
          end else begin
            mem_rdata = w;
          end
          active = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Issue one command at the current negedge (DUT idle) and check it end to end.
  task automatic do_cmd(input logic rd, input logic wr, input logic is32,
                        input logic [25:0] a, input logic [31:0] d,
                        input bit noise, output int bc);
    req_t e[$];
    logic [25:0] ab;
    int budget;
    int want_bc;
    reqs.delete();
    lats.delete();
    ab = {a[25:2], 2'b00};
    if (is32) begin
      e.push_back('{addr: a[25:1] & ~25'd1, we: wr, be: 2'b11, wdata: d[31:16]});
      e.push_back('{addr: a[25:1] | 25'd1, we: wr, be: 2'b11, wdata: d[15:0]});
      if (wr) begin
        rb[ab] = d[31:24]; rb[ab + 26'd1] = d[23:16];
        rb[ab + 26'd2] = d[15:8]; rb[ab + 26'd3] = d[7:0];
      end else begin
        exp_q = {gb(ab), gb(ab + 26'd1), gb(ab + 26'd2), gb(ab + 26'd3)};
      end
    end else begin
      e.push_back('{addr: a[25:1], we: wr, be: (a[0] ? 2'b01 : 2'b10), wdata: {d[7:0], d[7:0]}});
      if (wr) rb[a] = d[7:0];
      else exp_q = {4{gb(a)}};
    end
    word_rd = rd; word_wr = wr; word_32bit = is32; word_addr = a; word_data = d;
    @(negedge clk_sys);
    word_rd = 1'b0; word_wr = 1'b0;
    word_addr = 26'($urandom); word_data = $urandom;
    chk("busy_rise", 32'(word_busy), 32'd1);
    chk("req_rise", 32'(mem_req), 32'd1);
    bc = 0;
    budget = 0;
    while (word_busy && budget < 200) begin
      bc++;
      budget++;
      @(negedge clk_sys);
      word_rd = 1'b0; word_wr = 1'b0;
      if (noise && word_busy && $urandom_range(0, 1) == 0) begin
        word_wr = 1'b1; word_rd = 1'($urandom);
        word_32bit = 1'($urandom); word_addr = 26'($urandom); word_data = $urandom;
      end
    end
    chk("busy_timeout", 32'(budget < 200), 32'd1);
    chk("word_q", word_q, exp_q);
    chk("nreq", 32'(reqs.size()), 32'(e.size()));
    if (reqs.size() == e.size()) begin
      for (int i = 0; i < e.size(); i++) begin
        chk("req_addr", 32'(reqs[i].addr), 32'(e[i].addr));
        chk("req_we", 32'(reqs[i].we), 32'(e[i].we));
        chk("req_be", 32'(reqs[i].be), 32'(e[i].be));
        if (wr) chk("req_wdata", 32'(reqs[i].wdata), 32'(e[i].wdata));
      end
    end
    want_bc = is32 ? 1 : 0;
    foreach (lats[i]) want_bc += lats[i] + 1;
    chk("busy_len", 32'(bc), 32'(want_bc));
  endtask

  initial begin : main
    int bc;
    int budget;
    logic rd, wr;
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("rst_busy", 32'(word_busy), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_q", word_q, 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    force_lat = 0;
    do_cmd(1'b0, 1'b1, 1'b1, 26'h0001234, 32'hA1B2C3D4, 1'b0, bc);
    chk("w32_busy3", 32'(bc), 32'd3);

    rb[26'h10] = 8'h11; rb[26'h11] = 8'h22; rb[26'h12] = 8'h33; rb[26'h13] = 8'h44;
    mem16[25'h8] = 16'h1122; mem16[25'h9] = 16'h3344;
    force_lat = 2;
    do_cmd(1'b1, 1'b0, 1'b1, 26'h0000010, 32'h0, 1'b1, bc);
    chk("r32_busy7", 32'(bc), 32'd7);
    chk("r32_q", word_q, 32'h11223344);

    force_lat = -1;
    do_cmd(1'b0, 1'b1, 1'b0, 26'h0C00005, 32'h5A5A5A5A, 1'b1, bc);
    do_cmd(1'b0, 1'b1, 1'b0, 26'h0C00004, 32'h000000C3, 1'b1, bc);
    do_cmd(1'b1, 1'b0, 1'b1, 26'h0C00006, 32'h0, 1'b0, bc);
    chk("r32_after_bytes", word_q, {8'hC3, 8'h5A, exp_q[15:0]});

    // Reset while the second half of a read is outstanding.
    force_lat = 3;
    word_rd = 1'b1; word_32bit = 1'b1; word_addr = 26'h0000010;
    @(negedge clk_sys);
    word_rd = 1'b0;
    budget = 0;
    while (!(mem_req && mem_addr[0]) && budget < 50) begin
      budget++;
      @(negedge clk_sys);
    end
    chk("acc2_reached", 32'(budget < 50), 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(word_busy), 32'd0);
    chk("midrst_q", word_q, 32'd0);
    exp_q = '0;
    force_lat = -1;
    do_cmd(1'b1, 1'b0, 1'b1, 26'h0000010, 32'h0, 1'b0, bc);
    chk("post_rst_q", word_q, 32'h11223344);

    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      do_cmd(rd, wr, 1'($urandom), 26'h1550000 | 26'($urandom_range(0, 63)),
             $urandom, 1'b1, bc);
    end

    // Zero-gap build: request held across both halves, address bumps after first ack.
    g0_wr = 1'b1; g0_32 = 1'b1; g0_addr = 26'h0001234; g0_data = 32'hA1B2C3D4;
    @(negedge clk_sys);
    g0_wr = 1'b0;
    chk("g0_req1", 32'(g0_req), 32'd1);
    chk("g0_addr1", 32'(g0_maddr), 32'h00091A);
    chk("g0_wdata1", 32'(g0_wdata), 32'hA1B2);
    g0_ack = 1'b1;
    @(negedge clk_sys);
    chk("g0_req2", 32'(g0_req), 32'd1);
    chk("g0_addr2", 32'(g0_maddr), 32'h00091B);
    chk("g0_wdata2", 32'(g0_wdata), 32'hC3D4);
    @(negedge clk_sys);
    g0_ack = 1'b0;
    chk("g0_req_done", 32'(g0_req), 32'd0);
    chk("g0_busy_done", 32'(g0_busy), 32'd0);
    g0_rd = 1'b1; g0_addr = 26'h0000010;
    @(negedge clk_sys);
    g0_rd = 1'b0; g0_ack = 1'b1; g0_rdata = 16'h1122;
    @(negedge clk_sys);
    g0_rdata = 16'h3344;
    @(negedge clk_sys);
    g0_ack = 1'b0;
    chk("g0_busy_rd", 32'(g0_busy), 32'd0);
    chk("g0_q", g0_q, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
